// File: rtl/grid_loader.sv
// Parses an ASCII grid byte stream into one 1-bit BRAM write per cell, measuring width/height.
// Write latency 1 cycle after byte acceptance; in_ready is high only while loading.
module grid_loader #(
  parameter int ADDR_W = 17,
  parameter int DIM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_val,
  output logic              write_en,
  output logic [DIM_W-1:0]  grid_width,
  output logic [DIM_W-1:0]  grid_height,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  localparam logic [DIM_W-1:0]  DIM_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              r_state, w_state_nxt;
  logic [DIM_W-1:0]    r_col, r_row, r_width, r_height;
  logic [ADDR_W-1:0]   r_addr, r_wr_addr;
  logic                r_addr_full, r_wr_en, r_wr_val;

  logic                w_acc, w_is_cell, w_is_nl, w_is_cr, w_cell_val, w_col_nz;
  logic                w_close, w_fault, w_wr, w_finish, w_restart;
  logic [DIM_W-1:0]    w_cnt;

  always_comb begin
    w_acc      = in_valid && (r_state == S_LOAD);
    w_is_cell  = (in_data == 8'h23) || (in_data == 8'h40) || (in_data == 8'h2E);
    w_cell_val = (in_data != 8'h2E);
    w_is_nl    = (in_data == 8'h0A);
    w_is_cr    = (in_data == 8'h0D);
    w_col_nz   = (r_col != '0);
    // Cell count of the row being closed, including a cell that carries in_last.
    w_cnt      = w_is_cell ? r_col + DIM_W'(1) : r_col;
    w_close    = w_acc && ((w_is_nl && w_col_nz) ||
                           (in_last && (w_is_cell || (w_is_cr && w_col_nz))));
    w_fault    = w_acc && (!(w_is_cell || w_is_nl || w_is_cr) ||
                           (w_is_cell && ((r_col == DIM_MAX) || r_addr_full)) ||
                           (w_close && ((r_row == DIM_MAX) ||
                                        ((r_row != '0) && (w_cnt != r_width)))));
    w_wr       = w_acc && w_is_cell && !w_fault;
    w_finish   = w_acc && in_last && !w_fault;
    w_restart  = start && (r_state != S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_fault)       w_state_nxt = S_ERROR;
        else if (w_finish) w_state_nxt = S_DONE;
      end
      default: begin
        if (start) w_state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_addr      <= '0;
      r_addr_full <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_val    <= 1'b0;
      r_wr_en     <= 1'b0;
    end else if (w_restart) begin
      r_col       <= '0;
      r_row       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_addr      <= '0;
      r_addr_full <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_addr;
        r_wr_val  <= w_cell_val;
        r_addr    <= r_addr + ADDR_W'(1);
        r_col     <= r_col + DIM_W'(1);
        if (r_addr == ADDR_MAX) r_addr_full <= 1'b1;
      end
      // Closing a row overrides the column increment above.
      if (w_close && !w_fault) begin
        r_col    <= '0;
        r_row    <= r_row + DIM_W'(1);
        r_height <= r_row + DIM_W'(1);
        if (r_row == '0) r_width <= w_cnt;
      end
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERROR);
  assign write_en    = r_wr_en;
  assign write_val   = r_wr_val;
  assign write_addr  = r_wr_addr;
  assign grid_width  = r_width;
  assign grid_height = r_height;

endmodule

// File: tb/tb_grid_loader.sv
// Directed bench for grid_loader: streams small ASCII grids and checks writes, dimensions and status.
module tb_grid_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [16:0] write_addr;
  logic        write_val;
  logic        write_en;
  logic [8:0]  grid_width;
  logic [8:0]  grid_height;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] wq_addr[$];
  logic        wq_val[$];

  grid_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .write_addr(write_addr), .write_val(write_val), .write_en(write_en),
    .grid_width(grid_width), .grid_height(grid_height), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (write_en) begin
      wq_addr.push_back(write_addr);
      wq_val.push_back(write_val);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    wq_addr.delete();
    wq_val.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte from a negedge and returns on the negedge after it is accepted.
  task automatic send(input logic [7:0] b, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit throttle);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], i == s.len() - 1);
      if (throttle) repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag, input int n, input logic [15:0] v);
    repeat (2) @(negedge clk);
    chk({tag, "_nwr"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk({tag, "_addr"}, 32'(wq_addr[i]), i);
      chk({tag, "_val"}, 32'(wq_val[i]), 32'(v[i]));
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input int w, input int h);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_width"}, 32'(grid_width), w);
    chk({tag, "_height"}, 32'(grid_height), h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wen", 32'(write_en), 0);
    chk("rst_waddr", 32'(write_addr), 0);
    check_status("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 0);

    // Basic 3x2 grid, in_last on trailing newline
    do_start();
    chk("load_ready", 32'(in_ready), 1);
    send_str("#.#\n.#.\n", 0);
    chk("t1_ready_drop", 32'(in_ready), 0);
    check_writes("t1", 6, 16'h0015);
    check_status("t1", 1, 0, 3, 2);

    // No trailing newline: last on a cell closes the row
    do_start();
    send_str("@@\n.@", 0);
    check_writes("t2", 4, 16'h000B);
    check_status("t2", 1, 0, 2, 2);

    // Width mismatch on second row
    do_start();
    send_str("##\n###\n", 0);
    chk("t3_error_now", 32'(error), 1);
    chk("t3_ready_drop", 32'(in_ready), 0);
    check_writes("t3", 5, 16'h001F);
    chk("t3_done", 32'(done), 0);

    // Illegal byte, then recovery
    do_start();
    send_str("#.x", 0);
    check_writes("t4a", 2, 16'h0001);
    chk("t4a_error", 32'(error), 1);
    chk("t4a_done", 32'(done), 0);
    do_start();
    chk("t4_error_clr", 32'(error), 0);
    send_str("#\n", 0);
    check_writes("t4b", 1, 16'h0001);
    check_status("t4b", 1, 0, 1, 1);

    // Throttled stream with CR and blank line
    do_start();
    send_str("#\r\n.\r\n\n", 1);
    check_writes("t5", 2, 16'h0001);
    check_status("t5", 1, 0, 1, 2);

    // Async reset mid-row
    do_start();
    send("#", 0);
    send(".", 0);
    repeat (2) @(negedge clk);
    chk("t6_pre_waddr", 32'(write_addr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ready", 32'(in_ready), 0);
    chk("t6_wen", 32'(write_en), 0);
    chk("t6_waddr", 32'(write_addr), 0);
    check_status("t6", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wq_addr.delete();
    wq_val.delete();
    in_valid = 1'b1;
    in_data  = 8'h23;
    repeat (3) @(negedge clk);
    chk("t6_ready_hold", 32'(in_ready), 0);
    chk("t6_no_writes", wq_addr.size(), 0);
    in_valid = 1'b0;
    do_start();
    send_str("#\n", 0);
    check_writes("t6b", 1, 16'h0001);
    check_status("t6b", 1, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
